// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: EX request -> word-aligned data-memory bus access -> writeback or exception.
// Define LSU_WSTRB_EN for byte-strobed sub-word stores; otherwise sub-word stores read-modify-write the word.
`ifndef DATA_TYPE_BUS
`define DATA_TYPE_BUS 2:0
`endif
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef DATATYPE_BYTE
`define DATATYPE_BYTE 3'd0
`endif
`ifndef DATATYPE_HALF
`define DATATYPE_HALF 3'd1
`endif
`ifndef DATATYPE_WORD
`define DATATYPE_WORD 3'd2
`endif
`ifndef DATATYPE_UBYTE
`define DATATYPE_UBYTE 3'd3
`endif
`ifndef DATATYPE_UHALF
`define DATATYPE_UHALF 3'd4
`endif

module lsu_mem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  load_i,
    input  logic                  store_i,
    input  logic [`DATA_TYPE_BUS] data_type_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [`REG_ADDR_BUS]  rd_addr_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [31:0]           bus_wdata_o,
    output logic [3:0]            bus_wstrb_o,
    input  logic                  bus_ack_i,
    input  logic [31:0]           bus_rdata_i,
    input  logic                  bus_err_i,
    output logic                  wb_valid_o,
    output logic                  wb_reg_enable_o,
    output logic [`REG_ADDR_BUS]  wb_reg_addr_o,
    output logic [31:0]           wb_reg_data_o,
    output logic                  busy_o,
    output logic                  exc_valid_o,
    output logic [1:0]            exc_cause_o,
    output logic [ADDR_W-1:0]     exc_addr_o
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_RMW_READ, S_WRITE, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [`DATA_TYPE_BUS] type_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           wdata_q, rdata_q;
    logic [`REG_ADDR_BUS]  rd_q;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  exc_valid_q;
    logic [1:0]            exc_cause_q;
    logic [ADDR_W-1:0]     exc_addr_q;

    logic        in_byte, in_half, in_misaligned, accept, start;
    logic        q_byte, q_half, in_bus, timed_out, bus_fail, bus_ok;
    logic [1:0]  lane;
    logic [3:0]  lane_strb;
    logic [31:0] wdata_rep, rdata_shift, rdata_ext;

    assign in_byte = (data_type_i == `DATATYPE_BYTE) || (data_type_i == `DATATYPE_UBYTE);
    assign in_half = (data_type_i == `DATATYPE_HALF) || (data_type_i == `DATATYPE_UHALF);
    assign in_misaligned = (in_half && addr_i[0]) ||
                           (!in_byte && !in_half && (addr_i[1:0] != 2'b00));
    assign accept = req_valid_i && (state_q == S_IDLE) && (load_i || store_i);
    assign start  = accept && !in_misaligned;

    assign q_byte = (type_q == `DATATYPE_BYTE) || (type_q == `DATATYPE_UBYTE);
    assign q_half = (type_q == `DATATYPE_HALF) || (type_q == `DATATYPE_UHALF);
    assign lane   = addr_q[1:0];
    assign in_bus = (state_q == S_READ) || (state_q == S_RMW_READ) || (state_q == S_WRITE);

    // An ack arriving in the last allowed wait cycle still completes; an error always wins.
    assign timed_out = (TIMEOUT_MAX != 0) && (cnt_q == TIMEOUT_W'(TIMEOUT_MAX - 1));
    assign bus_fail  = in_bus && (bus_err_i || (timed_out && !bus_ack_i));
    assign bus_ok    = in_bus && bus_ack_i && !bus_err_i;

    always_comb begin
        lane_strb = 4'hF;
        wdata_rep = wdata_q;
        if (q_byte) begin
            lane_strb = 4'b0001 << lane;
            wdata_rep = {4{wdata_q[7:0]}};
        end else if (q_half) begin
            lane_strb = 4'b0011 << lane;
            wdata_rep = {2{wdata_q[15:0]}};
        end
    end

    assign rdata_shift = bus_rdata_i >> {lane, 3'b000};

    always_comb begin
        rdata_ext = rdata_shift;
        case (type_q)
            `DATATYPE_BYTE:  rdata_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            `DATATYPE_UBYTE: rdata_ext = {24'h0, rdata_shift[7:0]};
            `DATATYPE_HALF:  rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            `DATATYPE_UHALF: rdata_ext = {16'h0, rdata_shift[15:0]};
            default:         rdata_ext = rdata_shift;
        endcase
    end

`ifndef LSU_WSTRB_EN
    logic [31:0] rmw_merged;
    always_comb begin
        rmw_merged = bus_rdata_i;
        for (int i = 0; i < 4; i++) begin
            if (lane_strb[i]) rmw_merged[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (load_i) state_d = S_READ;
`ifdef LSU_WSTRB_EN
                    else        state_d = S_WRITE;
`else
                    else        state_d = (in_byte || in_half) ? S_RMW_READ : S_WRITE;
`endif
                end
            end
            S_READ: begin
                if (bus_fail)    state_d = S_IDLE;
                else if (bus_ok) state_d = S_RESP;
            end
            S_RMW_READ: begin
                if (bus_fail)    state_d = S_IDLE;
                else if (bus_ok) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus_fail || bus_ok) state_d = S_IDLE;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o     = (state_q == S_IDLE);
        busy_o          = !req_ready_o;
        bus_req_o       = in_bus;
        bus_we_o        = (state_q == S_WRITE);
        bus_addr_o      = {addr_q[ADDR_W-1:2], 2'b00};
`ifdef LSU_WSTRB_EN
        bus_wdata_o     = wdata_rep;
        bus_wstrb_o     = lane_strb;
`else
        bus_wdata_o     = wdata_q;
        bus_wstrb_o     = 4'hF;
`endif
        wb_valid_o      = (state_q == S_RESP);
        wb_reg_enable_o = wb_valid_o && (rd_q != '0);
        wb_reg_addr_o   = rd_q;
        wb_reg_data_o   = rdata_q;
        exc_valid_o     = exc_valid_q;
        exc_cause_o     = exc_cause_q;
        exc_addr_o      = exc_addr_q;
    end

    // Wait counter restarts whenever the state changes, so each bus transfer gets its own budget.
    assign cnt_d = (state_d != state_q) ? '0 : cnt_q + TIMEOUT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 2'd0;
            exc_addr_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            exc_valid_q <= 1'b0;
            if (accept) begin
                type_q  <= data_type_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                rd_q    <= rd_addr_i;
            end
            if (accept && in_misaligned) begin
                exc_valid_q <= 1'b1;
                exc_cause_q <= {1'b0, store_i};
                exc_addr_q  <= addr_i;
            end
            if (bus_fail) begin
                exc_valid_q <= 1'b1;
                exc_cause_q <= {1'b1, state_q != S_READ};
                exc_addr_q  <= addr_q;
            end
            if (bus_ok && (state_q == S_READ)) rdata_q <= rdata_ext;
`ifndef LSU_WSTRB_EN
            if (bus_ok && (state_q == S_RMW_READ)) wdata_q <= rmw_merged;
`endif
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, mid-access reset, and random accesses vs. a reference model.
`ifndef DATA_TYPE_BUS
`define DATA_TYPE_BUS 2:0
`endif
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef DATATYPE_BYTE
`define DATATYPE_BYTE 3'd0
`endif
`ifndef DATATYPE_HALF
`define DATATYPE_HALF 3'd1
`endif
`ifndef DATATYPE_WORD
`define DATATYPE_WORD 3'd2
`endif
`ifndef DATATYPE_UBYTE
`define DATATYPE_UBYTE 3'd3
`endif
`ifndef DATATYPE_UHALF
`define DATATYPE_UHALF 3'd4
`endif

module tb_lsu_mem_ctrl;
    localparam int TMAX = 4;
`ifdef LSU_WSTRB_EN
    localparam int RX = 0;
`else
    localparam int RX = 1;
`endif

    logic        clk, rst_n;
    logic        req_valid_i, req_ready_o, load_i, store_i;
    logic [2:0]  data_type_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rd_addr_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_ack_i, bus_err_i;
    logic [31:0] bus_rdata_i;
    logic        wb_valid_o, wb_reg_enable_o;
    logic [4:0]  wb_reg_addr_o;
    logic [31:0] wb_reg_data_o;
    logic        busy_o, exc_valid_o;
    logic [1:0]  exc_cause_o;
    logic [31:0] exc_addr_o;

    lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_W(8), .TIMEOUT_MAX(TMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .load_i(load_i), .store_i(store_i), .data_type_i(data_type_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
        .wb_valid_o(wb_valid_o), .wb_reg_enable_o(wb_reg_enable_o),
        .wb_reg_addr_o(wb_reg_addr_o), .wb_reg_data_o(wb_reg_data_o),
        .busy_o(busy_o), .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o),
        .exc_addr_o(exc_addr_o)
    );

    typedef struct {
        logic ld; logic st; logic [2:0] typ; logic [31:0] addr; logic [31:0] wdata; logic [4:0] rd;
        logic [31:0] init; int d; logic err; logic errack; logic never;
        logic e_wb; logic [31:0] e_data; logic e_en; logic e_exc; logic [1:0] e_cause; int e_ready;
        logic [31:0] e_mem;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus slave ----------------
    logic [31:0] mem [16];
    int          rsp_d = 0;
    bit          rsp_err = 0, rsp_errack = 0, rsp_never = 0;
    int          wcnt = 0;
    int          nwrites = 0;
    logic [31:0] last_wdata, hold_addr, hold_wdata;
    logic [3:0]  last_wstrb, hold_wstrb;
    logic        hold_we;

    initial begin
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (bus_ack_i || bus_err_i || !bus_req_o) wcnt = 0;
            bus_ack_i = 1'b0;
            bus_err_i = 1'b0;
            if (bus_req_o) begin
                if (wcnt == 0) begin
                    hold_addr = bus_addr_o; hold_wdata = bus_wdata_o;
                    hold_wstrb = bus_wstrb_o; hold_we = bus_we_o;
                end else begin
                    checks++;
                    if ({hold_addr, hold_wdata, hold_wstrb, hold_we} !==
                        {bus_addr_o, bus_wdata_o, bus_wstrb_o, bus_we_o}) begin
                        errors++;
                        $display("FAIL bus_stable got %h/%h/%h/%b exp %h/%h/%h/%b", bus_addr_o, bus_wdata_o,
                                 bus_wstrb_o, bus_we_o, hold_addr, hold_wdata, hold_wstrb, hold_we);
                    end
                end
                if (!rsp_never && wcnt == rsp_d) begin
                    if (rsp_err) begin
                        bus_err_i = 1'b1;
                        bus_ack_i = rsp_errack;
                        bus_rdata_i = $urandom;
                    end else begin
                        bus_ack_i = 1'b1;
                        bus_rdata_i = mem[bus_addr_o[5:2]];
                        if (bus_we_o) begin
                            for (int i = 0; i < 4; i++)
                                if (bus_wstrb_o[i]) mem[bus_addr_o[5:2]][8*i +: 8] = bus_wdata_o[8*i +: 8];
                            nwrites++;
                            last_wdata = bus_wdata_o;
                            last_wstrb = bus_wstrb_o;
                        end
                    end
                end
                wcnt++;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int tsize(input logic [2:0] t);
        if (t == `DATATYPE_BYTE || t == `DATATYPE_UBYTE) return 1;
        if (t == `DATATYPE_HALF || t == `DATATYPE_UHALF) return 2;
        return 4;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r; int sz; int lane; int extra; logic [31:0] x;
        r = v; sz = tsize(v.typ); lane = int'(v.addr[1:0]); extra = 0;
        r.e_wb = 0; r.e_data = '0; r.e_en = 0; r.e_exc = 0; r.e_cause = 2'd0; r.e_mem = v.init;
`ifndef LSU_WSTRB_EN
        if (v.st && sz < 4) extra = 1 + v.d;
`endif
        if ((sz == 2 && v.addr[0]) || (sz == 4 && v.addr[1:0] != 2'b00)) begin
            r.e_exc = 1; r.e_cause = v.st ? 2'd1 : 2'd0; r.e_ready = 1;
        end else if (v.never) begin
            r.e_exc = 1; r.e_cause = v.st ? 2'd3 : 2'd2; r.e_ready = 1 + TMAX;
        end else if (v.err) begin
            r.e_exc = 1; r.e_cause = v.st ? 2'd3 : 2'd2; r.e_ready = 2 + v.d;
        end else if (v.ld) begin
            x = v.init >> (8 * lane);
            if (sz == 1) begin
                x = x % 256;
                if (v.typ == `DATATYPE_BYTE && x >= 128) x = x - 256;
            end else if (sz == 2) begin
                x = x % 65536;
                if (v.typ == `DATATYPE_HALF && x >= 32768) x = x - 65536;
            end
            r.e_wb = 1; r.e_data = x; r.e_en = (v.rd != 0); r.e_ready = 3 + v.d;
        end else begin
            x = v.init;
            for (int k = 0; k < sz; k++) x[8*(lane+k) +: 8] = v.wdata[8*k +: 8];
            r.e_mem = x; r.e_ready = 2 + v.d + extra;
        end
        return r;
    endfunction

    function automatic void exp_write(input vec_t v, output logic [31:0] d, output logic [3:0] s);
        int sz; int lane;
        sz = tsize(v.typ); lane = int'(v.addr[1:0]); d = '0;
`ifdef LSU_WSTRB_EN
        s = 4'(((1 << sz) - 1) << lane);
        for (int i = 0; i < 4; i++) d[8*i +: 8] = v.wdata[8*(i % sz) +: 8];
`else
        s = 4'hF;
        d = v.e_mem;
`endif
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h exp %h", name, tag, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        int idx, wb_cnt, exc_cnt, reqc, ready_n, wb_n;
        logic [31:0] wb_data, first_addr, exc_addr, ewd;
        logic [4:0]  wb_rd;
        logic [3:0]  ews;
        logic        wb_en;
        logic [1:0]  cause;
        idx = int'(v.addr[5:2]);
        wb_cnt = 0; exc_cnt = 0; reqc = 0; ready_n = 0; wb_n = 0;
        wb_data = '0; first_addr = '0; exc_addr = '0; wb_rd = '0; wb_en = 0; cause = 2'd0;
        @(negedge clk);
        mem[idx] = v.init;
        rsp_d = v.d; rsp_err = v.err; rsp_errack = v.errack; rsp_never = v.never; nwrites = 0;
        req_valid_i = 1'b1; load_i = v.ld; store_i = v.st; data_type_i = v.typ;
        addr_i = v.addr; wdata_i = v.wdata; rd_addr_i = v.rd;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            req_valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
            if (bus_req_o) begin
                if (reqc == 0) first_addr = bus_addr_o;
                reqc++;
            end
            if (wb_valid_o) begin
                wb_cnt++; wb_n = n; wb_data = wb_reg_data_o; wb_en = wb_reg_enable_o; wb_rd = wb_reg_addr_o;
            end
            if (exc_valid_o) begin
                exc_cnt++; cause = exc_cause_o; exc_addr = exc_addr_o;
            end
            if (req_ready_o) begin
                ready_n = n;
                break;
            end
        end
        check("ready_cycle", tag, ready_n, v.e_ready);
        check("exc_pulses", tag, exc_cnt, v.e_exc ? 1 : 0);
        check("wb_pulses", tag, wb_cnt, v.e_wb ? 1 : 0);
        if (v.e_exc) begin
            check("exc_cause", tag, cause, v.e_cause);
            check("exc_addr", tag, exc_addr, v.addr);
        end
        if (v.e_wb) begin
            check("wb_data", tag, wb_data, v.e_data);
            check("wb_enable", tag, wb_en, v.e_en);
            check("wb_rd", tag, wb_rd, v.rd);
            check("wb_cycle", tag, wb_n, v.e_ready - 1);
        end
        if (v.e_exc && v.e_cause < 2)  check("misalign_no_req", tag, reqc, 0);
        else if (v.never)              check("timeout_req_cycles", tag, reqc, TMAX);
        else                           check("bus_addr", tag, first_addr, {v.addr[31:2], 2'b00});
        check("num_writes", tag, nwrites, (v.st && !v.e_exc) ? 1 : 0);
        if (v.st && !v.e_exc) begin
            exp_write(v, ewd, ews);
            check("bus_wdata", tag, last_wdata, ewd);
            check("bus_wstrb", tag, last_wstrb, ews);
        end
        check("mem_word", tag, mem[idx], v.e_mem);
    endtask

    // ---------------- main sequence ----------------
    vec_t tbl [15];
    vec_t rv;

    initial begin
        rst_n = 1'b0;
        req_valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0; data_type_i = '0;
        addr_i = '0; wdata_i = '0; rd_addr_i = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        //            ld    st    typ              addr          wdata         rd     init          d  err   eack  nev   e_wb  e_data        e_en  e_exc cause  rdy    e_mem
        tbl[0]  = '{1'b1, 1'b0, `DATATYPE_BYTE,  32'h0000_1003, 32'h0,        5'd5,  32'h80FF_FF12, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 2'd0, 3,      32'h80FF_FF12};
        tbl[1]  = '{1'b1, 1'b0, `DATATYPE_UHALF, 32'h0000_2002, 32'h0,        5'd7,  32'hBEEF_1234, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 1'b1, 1'b0, 2'd0, 4,      32'hBEEF_1234};
        tbl[2]  = '{1'b1, 1'b0, `DATATYPE_HALF,  32'h0000_2002, 32'h0,        5'd7,  32'hBEEF_1234, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_BEEF, 1'b1, 1'b0, 2'd0, 3,      32'hBEEF_1234};
        tbl[3]  = '{1'b1, 1'b0, `DATATYPE_HALF,  32'h0000_2002, 32'h0,        5'd0,  32'hBEEF_1234, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_BEEF, 1'b0, 1'b0, 2'd0, 3,      32'hBEEF_1234};
        tbl[4]  = '{1'b0, 1'b1, `DATATYPE_BYTE,  32'h0000_3001, 32'h0000_00AB, 5'd0,  32'h1122_3344, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2 + RX, 32'h1122_AB44};
        tbl[5]  = '{1'b1, 1'b0, `DATATYPE_WORD,  32'h0000_4002, 32'h0,        5'd1,  32'h5555_5555, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0, 1,      32'h5555_5555};
        tbl[6]  = '{1'b0, 1'b1, `DATATYPE_HALF,  32'h0000_4001, 32'h0000_1234, 5'd0,  32'h6666_6666, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'd1, 1,      32'h6666_6666};
        tbl[7]  = '{1'b0, 1'b1, `DATATYPE_WORD,  32'h0000_5000, 32'hDEAD_BEEF, 5'd0,  32'h0102_0304, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd3, 5,      32'h0102_0304};
        tbl[8]  = '{1'b1, 1'b0, `DATATYPE_WORD,  32'h0000_6000, 32'h0,        5'd9,  32'h7777_7777, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'd2, 2,      32'h7777_7777};
        tbl[9]  = '{1'b0, 1'b1, `DATATYPE_BYTE,  32'h0000_7002, 32'h0000_00CD, 5'd0,  32'h0A0B_0C0D, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd3, 5,      32'h0A0B_0C0D};
        tbl[10] = '{1'b1, 1'b0, `DATATYPE_UBYTE, 32'h0000_0001, 32'h0,        5'd3,  32'h0000_9A00, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_009A, 1'b1, 1'b0, 2'd0, 5,      32'h0000_9A00};
        tbl[11] = '{1'b0, 1'b1, `DATATYPE_UHALF, 32'h0000_0802, 32'h1234_CAFE, 5'd0,  32'hAAAA_BBBB, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2 + RX, 32'hCAFE_BBBB};
        tbl[12] = '{1'b0, 1'b1, `DATATYPE_WORD,  32'h0000_0C00, 32'h0BAD_F00D, 5'd0,  32'h0000_0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 3,      32'h0BAD_F00D};
        tbl[13] = '{1'b1, 1'b0, `DATATYPE_WORD,  32'h0000_0C04, 32'h0,        5'd31, 32'h89AB_CDEF, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h89AB_CDEF, 1'b1, 1'b0, 2'd0, 6,      32'h89AB_CDEF};
        tbl[14] = '{1'b0, 1'b1, `DATATYPE_BYTE,  32'h0000_0C05, 32'h0000_005A, 5'd0,  32'h1111_1111, 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 2'd3, 4,      32'h1111_1111};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", -1, req_ready_o, 1);
        check("rst_busy", -1, busy_o, 0);
        check("rst_bus_req", -1, bus_req_o, 0);
        check("rst_wb_valid", -1, wb_valid_o, 0);
        check("rst_exc_valid", -1, exc_valid_o, 0);
        rst_n = 1'b1;

        // Reset while a load waits on the bus
        @(negedge clk);
        rsp_never = 1; rsp_err = 0; rsp_d = 0;
        req_valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; data_type_i = `DATATYPE_WORD;
        addr_i = 32'h0000_0100; wdata_i = '0; rd_addr_i = 5'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0; load_i = 1'b0;
        @(negedge clk);
        check("midrst_req_before", -2, bus_req_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req_drop", -2, bus_req_o, 0);
        check("midrst_ready", -2, req_ready_o, 1);
        check("midrst_busy", -2, busy_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_wb", -2, wb_valid_o, 0);
            check("midrst_no_exc", -2, exc_valid_o, 0);
        end
        rst_n = 1'b1;
        rsp_never = 0;

        // Directed table
        for (int i = 0; i < 15; i++) run_vec(tbl[i], i);

        // Random accesses against the model
        for (int i = 0; i < 150; i++) begin
            rv.ld = 1'(($urandom_range(0, 1)));
            rv.st = !rv.ld;
            rv.typ = 3'($urandom_range(0, 4));
            rv.addr = $urandom;
            rv.wdata = $urandom;
            rv.rd = 5'($urandom_range(0, 31));
            rv.init = $urandom;
            rv.d = $urandom_range(0, 3);
            rv.err = ($urandom_range(0, 7) == 0);
            rv.errack = 1'($urandom_range(0, 1));
            rv.never = !rv.err && ($urandom_range(0, 15) == 0);
            run_vec(model(rv), 100 + i);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Multi-cycle load/store unit between EX and the data-memory bus; replaces the combinational mem-stage data path.
- Adds a req/ack bus handshake, byte-lane alignment, sign/zero extension for all `datatype_*` codes, correct sub-word stores, misalignment and timeout exceptions.
- Stalls the pipeline through busy_o while an access is in flight.

Parameters:
ADDR_W, 32, byte-address width of addr_i and bus_addr_o
TIMEOUT_W, 8, width of the bus-wait counter
TIMEOUT_MAX, 255, cycles waited for bus_ack before an access fault; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_valid_i  in  1  EX presents an access
req_ready_o  out  1  unit idle; access accepted when req_valid_i && req_ready_o
load_i  in  1  access is a load
store_i  in  1  access is a store; load_i and store_i are never both 1
data_type_i  in  `data_type_bus  byte/half/word/ubyte/uhalf (`datatype_* codes)
addr_i  in  ADDR_W  byte address
wdata_i  in  32  store data, LSB-aligned
rd_addr_i  in  `reg_addr_bus  load destination register
bus_req_o  out  1  bus request, held until ack/err/timeout
bus_we_o  out  1  1 = write
bus_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
bus_wdata_o  out  32  write data, lane-positioned
bus_wstrb_o  out  4  byte write strobes
bus_ack_i  in  1  transfer complete; read data valid in the same cycle
bus_rdata_i  in  32  read data
bus_err_i  in  1  slave error
wb_valid_o  out  1  one-cycle load result pulse
wb_reg_enable_o  out  1  wb_valid_o && rd != 0
wb_reg_addr_o  out  `reg_addr_bus  load destination
wb_reg_data_o  out  32  extended load data
busy_o  out  1  ~req_ready_o; pipeline stall
exc_valid_o  out  1  one-cycle exception pulse
exc_cause_o  out  2  0 load misaligned, 1 store misaligned, 2 load fault, 3 store fault
exc_addr_o  out  ADDR_W  faulting byte address

Behaviour:
- Reset (async, rst_n=0): state IDLE; all registered outputs 0; req_ready_o=1 and busy_o=0. Reset mid-access drops bus_req_o immediately and produces no writeback and no exception.
- States: IDLE, READ, RMW_READ, WRITE, RESP. req_ready_o = (state==IDLE).
- Accept (cycle T): latch type, addr, wdata, rd, lane = addr[1:0].
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0 -> no bus access; exc_valid_o pulses at T+1 with cause 0/1 and exc_addr_o=addr; state stays IDLE.
- bus_req_o is registered and first asserted at T+1. An ack in that same cycle completes the transfer.
- Load: READ. On ack, capture ext(bus_rdata >> 8*lane) and go to RESP. RESP drives wb_valid_o for 1 cycle, then IDLE. Minimum load: accept T, wb_valid T+2, ready again T+3.
- Extension: byte sign bit = extracted[7]; half sign bit = extracted[15]; ubyte/uhalf zero-extend; word unchanged.
- Store: WRITE with bus_we_o=1. bus_wdata_o replicates wdata across lanes (byte x4, half x2).
  - bus_wstrb_o: byte 4'b0001<<lane, half 4'b0011<<lane, word 4'hF.
  - On ack go to IDLE; no writeback. Minimum store: ready again T+2.
- bus_addr_o, bus_we_o, bus_wdata_o and bus_wstrb_o are stable while bus_req_o=1.
- Timeout: counter clears on entry to any bus state and increments each waiting cycle.
  - Reaching TIMEOUT_MAX, or bus_err_i=1, drops bus_req_o, pulses exc_valid_o (cause 2/3, the original byte address) and returns to IDLE. No writeback.
  - bus_err_i together with bus_ack_i: the error wins.
- ubyte/uhalf on a store behave as byte/half.

Optional Feature:
LSU_WSTRB_EN
- Defined: sub-word stores are a single WRITE with partial strobes, as described above.
- Undefined: bus_wstrb_o is tied to 4'hF. Byte/half stores run RMW_READ (read the word), merge wdata into the lanes, then WRITE the full word. Minimum sub-word store: ready again T+3.
  - An error or timeout in RMW_READ reports cause 3 and issues no write.
- Word stores are identical in both builds.

Test Plan:
- Load byte, addr 0x1003, rdata 0x80FF_FF12, rd=5 -> bus_addr 0x1000; wb_reg_data 0xFFFF_FF80, wb_reg_enable 1, wb_valid at T+2.
- Load uhalf, addr 0x2002, rdata 0xBEEF_1234 -> wb_reg_data 0x0000_BEEF. Repeat as half -> 0xFFFF_BEEF. Repeat with rd=0 -> wb_reg_enable 0.
- Store byte 0xAB at 0x3001, memory word 0x1122_3344. With LSU_WSTRB_EN: wdata 0xABAB_ABAB, wstrb 4'b0010. Without: RMW read, then write 0x1122_AB44, wstrb 4'hF. Final memory 0x1122_AB44 in both builds.
- Word load at 0x4002 -> no bus_req_o, exc_valid at T+1, cause 0, exc_addr 0x4002. Half store at 0x4001 -> cause 1.
- TIMEOUT_MAX=4, ack never asserted on a store -> bus_req_o drops after 4 wait cycles, cause 3. bus_err_i and bus_ack_i together on a load -> cause 2, no wb_valid.
- rst_n low while READ is pending -> bus_req_o 0 immediately, req_ready_o 1, no wb_valid/exc_valid. Next load completes normally.
